// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO accumulator: opcode encoding and the per-stage
// record carried alongside the multiplier pipeline.
package hilo_pkg;

  localparam int HILO_OP_W     = 3;
  // Widest HI/LO word the stage record can carry; narrower builds leave upper bits zero.
  localparam int HILO_DATA_MAX = 64;

  typedef enum logic [HILO_OP_W-1:0] {
    HILO_NOP  = 3'd0,
    HILO_MULT = 3'd1,
    HILO_MADD = 3'd2,
    HILO_MSUB = 3'd3,
    HILO_MTHI = 3'd4,
    HILO_MTLO = 3'd5,
    HILO_CLR  = 3'd6,
    HILO_RSVD = 3'd7
  } hilo_op_t;

  typedef struct packed {
    logic                     valid;
    hilo_op_t                 op;
    logic [HILO_DATA_MAX-1:0] wdata;
  } hilo_stage_t;

endpackage

// File: rtl/hilo_op_delay.sv
// LATENCY-stage register chain that holds each issued op until its product
// emerges from the multiplier; busy_o is the OR of all in-flight valids.
module hilo_op_delay
  import hilo_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  hilo_stage_t stage_i,
  output hilo_stage_t stage_o,
  output logic        busy_o
);

  if (LATENCY < 1) begin : g_lat_chk
    $fatal(1, "hilo_op_delay: LATENCY must be >= 1");
  end

  hilo_stage_t stage_q [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= stage_i;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign stage_o = stage_q[LATENCY-1];

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < LATENCY; i++) busy_o = busy_o | stage_q[i].valid;
  end

endmodule

// File: rtl/hilo_accumulator.sv
// Architectural HI/LO pair retiring MULT/MADD/MSUB/MTHI/MTLO/CLR against the
// multiplier product. Define HILO_SATURATE_EN for signed saturating MADD/MSUB and sticky ovf.
module hilo_accumulator
  import hilo_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [HILO_OP_W-1:0] issue_op,
  input  logic [WIDTH-1:0]     issue_wdata,
  input  logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  localparam int PW = 2 * WIDTH;

  if (LATENCY < 1) begin : g_lat_chk
    $fatal(1, "hilo_accumulator: LATENCY must be >= 1");
  end
  if (WIDTH > HILO_DATA_MAX) begin : g_w_chk
    $fatal(1, "hilo_accumulator: WIDTH exceeds HILO_DATA_MAX");
  end

  hilo_stage_t in_s, ret_s;

  always_comb begin
    in_s                   = '0;
    in_s.valid             = issue_valid;
    in_s.op                = hilo_op_t'(issue_op);
    in_s.wdata[WIDTH-1:0]  = issue_wdata;
  end

  hilo_op_delay #(.LATENCY(LATENCY)) u_dly (
    .clk     (clk),
    .reset   (reset),
    .stage_i (in_s),
    .stage_o (ret_s),
    .busy_o  (busy)
  );

  // Upper record bits beyond WIDTH are always zero and intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^ret_s.wdata;

  logic [PW-1:0] hilo_q, hilo_d, sum, diff;
  logic          done_q, done_d;

  assign sum  = hilo_q + product;
  assign diff = hilo_q - product;

`ifdef HILO_SATURATE_EN
  localparam logic [PW-1:0] SMAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] SMIN = {1'b1, {(PW-1){1'b0}}};
  logic          ovf_q, ovf_d, add_ov, sub_ov;
  logic [PW-1:0] clamp;

  assign add_ov = (hilo_q[PW-1] == product[PW-1]) && (sum[PW-1]  != hilo_q[PW-1]);
  assign sub_ov = (hilo_q[PW-1] != product[PW-1]) && (diff[PW-1] != hilo_q[PW-1]);
  // Signed overflow always runs away in the direction of the accumulator's sign.
  assign clamp  = hilo_q[PW-1] ? SMIN : SMAX;
  assign ovf    = ovf_q;
`else
  assign ovf    = 1'b0;
`endif

  always_comb begin
    hilo_d = hilo_q;
    done_d = 1'b0;
`ifdef HILO_SATURATE_EN
    ovf_d  = ovf_q;
`endif
    if (ret_s.valid) begin
      done_d = (ret_s.op != HILO_NOP);
      case (ret_s.op)
        HILO_MULT: hilo_d = product;
`ifdef HILO_SATURATE_EN
        HILO_MADD: begin
          hilo_d = add_ov ? clamp : sum;
          if (add_ov) ovf_d = 1'b1;
        end
        HILO_MSUB: begin
          hilo_d = sub_ov ? clamp : diff;
          if (sub_ov) ovf_d = 1'b1;
        end
        HILO_CLR: begin
          hilo_d = '0;
          ovf_d  = 1'b0;
        end
`else
        HILO_MADD: hilo_d = sum;
        HILO_MSUB: hilo_d = diff;
        HILO_CLR:  hilo_d = '0;
`endif
        HILO_MTHI: hilo_d[PW-1:WIDTH] = ret_s.wdata[WIDTH-1:0];
        HILO_MTLO: hilo_d[WIDTH-1:0]  = ret_s.wdata[WIDTH-1:0];
        default:   hilo_d = hilo_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hilo_q <= '0;
      done_q <= 1'b0;
`ifdef HILO_SATURATE_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      hilo_q <= hilo_d;
      done_q <= done_d;
`ifdef HILO_SATURATE_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign hi   = hilo_q[PW-1:WIDTH];
  assign lo   = hilo_q[WIDTH-1:0];
  assign done = done_q;

endmodule
